// File: rtl/timer_pkg.sv
// Shared timer constants: TCR/TSR bit positions and counter wrap values.
// Used by the counter block and by the status logic.
package timer_pkg;

    localparam int unsigned TCR_LOAD = 7;
    localparam int unsigned TCR_EN   = 4;
    localparam int unsigned TCR_DIR  = 3;

    localparam int unsigned TSR_OVF    = 0;
    localparam int unsigned TSR_UDF    = 1;
    localparam int unsigned TSR_OVF_OR = 2;
    localparam int unsigned TSR_UDF_OR = 3;

    localparam logic [7:0] CNT_MAX = 8'hFF;
    localparam logic [7:0] CNT_MIN = 8'h00;

    typedef struct packed {
        logic ovf;
        logic udf;
    } wrap_evt_t;

endpackage

// File: rtl/timer_status_wrap_detect.sv
// Wrap comparator: flags FF->00 (up) and 00->FF (down) transitions,
// masked while a load is in progress or was in the previous cycle.
module wrap_detect
    import timer_pkg::*;
(
    input  logic [7:0] counter_signal,
    input  logic [7:0] last_counter,
    input  logic       dir,
    input  logic       load,
    input  logic       load_d,
    output logic       ovf_evt,
    output logic       udf_evt
);

    logic no_load;

    assign no_load = !load && !load_d;

    assign ovf_evt = no_load && !dir
                  && (last_counter == CNT_MAX)
                  && (counter_signal == CNT_MIN);

    assign udf_evt = no_load && dir
                  && (last_counter == CNT_MIN)
                  && (counter_signal == CNT_MAX);

endmodule

// File: rtl/timer_status.sv
// Timer status: sticky overflow/underflow flags with overrun bits
// and level interrupts gated by the enables.
module timer_status
    import timer_pkg::*;
(
    input  logic       pclk,
    input  logic       preset_n,
    input  logic [7:0] counter_signal,
    input  logic [7:0] last_counter,
    input  logic [7:0] TCR,
    input  logic       ovf_clr,
    input  logic       udf_clr,
    input  logic       ovf_ie,
    input  logic       udf_ie,
    output logic [3:0] TSR,
    output logic       tmr_ovf_irq,
    output logic       tmr_udf_irq
);

    logic      load_d;
    wrap_evt_t evt;
    logic      unused_tcr;

    // Enable is irrelevant here: a wrap can only be seen while counting.
    assign unused_tcr = ^{TCR[6:4], TCR[2:0]};

    wrap_detect u_wrap (
        .counter_signal (counter_signal),
        .last_counter   (last_counter),
        .dir            (TCR[TCR_DIR]),
        .load           (TCR[TCR_LOAD]),
        .load_d         (load_d),
        .ovf_evt        (evt.ovf),
        .udf_evt        (evt.udf)
    );

    always_ff @(posedge pclk or posedge preset_n) begin
        if (preset_n) begin
            load_d <= 1'b0;
            TSR    <= 4'h0;
        end else begin
            load_d <= TCR[TCR_LOAD];

            if (evt.ovf)
                TSR[TSR_OVF] <= 1'b1;
            else if (ovf_clr)
                TSR[TSR_OVF] <= 1'b0;

            // A coinciding clear wins for overrun; set wins for the flag.
            if (evt.ovf && TSR[TSR_OVF] && !ovf_clr)
                TSR[TSR_OVF_OR] <= 1'b1;
            else if (ovf_clr)
                TSR[TSR_OVF_OR] <= 1'b0;

            if (evt.udf)
                TSR[TSR_UDF] <= 1'b1;
            else if (udf_clr)
                TSR[TSR_UDF] <= 1'b0;

            if (evt.udf && TSR[TSR_UDF] && !udf_clr)
                TSR[TSR_UDF_OR] <= 1'b1;
            else if (udf_clr)
                TSR[TSR_UDF_OR] <= 1'b0;
        end
    end

    assign tmr_ovf_irq = TSR[TSR_OVF] & ovf_ie;
    assign tmr_udf_irq = TSR[TSR_UDF] & udf_ie;

endmodule

// File: tb/tb_timer_status.sv
// Randomized and directed bench for timer_status against a
// flag-level reference model of the status register.
module tb_timer_status;

    logic       pclk = 1'b0;
    logic       preset_n;
    logic [7:0] counter_signal;
    logic [7:0] last_counter;
    logic [7:0] TCR;
    logic       ovf_clr;
    logic       udf_clr;
    logic       ovf_ie;
    logic       udf_ie;
    logic [3:0] TSR;
    logic       tmr_ovf_irq;
    logic       tmr_udf_irq;

    int total = 0;
    int bad   = 0;

    bit m_load;
    bit m_ovf, m_udf, m_ovr, m_udr;

    always #5 pclk = ~pclk;

    timer_status dut (
        .pclk           (pclk),
        .preset_n       (preset_n),
        .counter_signal (counter_signal),
        .last_counter   (last_counter),
        .TCR            (TCR),
        .ovf_clr        (ovf_clr),
        .udf_clr        (udf_clr),
        .ovf_ie         (ovf_ie),
        .udf_ie         (udf_ie),
        .TSR            (TSR),
        .tmr_ovf_irq    (tmr_ovf_irq),
        .tmr_udf_irq    (tmr_udf_irq)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] m_tsr();
        return {m_udr, m_ovr, m_udf, m_ovf};
    endfunction

    task automatic m_reset();
        m_load = 0;
        m_ovf = 0; m_udf = 0; m_ovr = 0; m_udr = 0;
    endtask

    // Apply the flag rules to the inputs seen at this rising edge.
    task automatic m_edge();
        bit ov, un, quiet;
        quiet = !TCR[7] && !m_load;
        ov = quiet && !TCR[3] && last_counter == 8'hFF
             && counter_signal == 8'h00;
        un = quiet && TCR[3] && last_counter == 8'h00
             && counter_signal == 8'hFF;
        m_ovr = ovf_clr ? 1'b0 : (m_ovr || (ov && m_ovf));
        m_udr = udf_clr ? 1'b0 : (m_udr || (un && m_udf));
        m_ovf = ov || (m_ovf && !ovf_clr);
        m_udf = un || (m_udf && !udf_clr);
        m_load = TCR[7];
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".tsr"}, {4'h0, TSR}, {4'h0, m_tsr()});
        chk({tag, ".oirq"}, {7'h0, tmr_ovf_irq}, {7'h0, m_ovf & ovf_ie});
        chk({tag, ".uirq"}, {7'h0, tmr_udf_irq}, {7'h0, m_udf & udf_ie});
    endtask

    // Inputs are set before the call; strobes drop after the edge.
    task automatic step(input string tag);
        @(posedge pclk);
        if (!preset_n) m_edge();
        @(negedge pclk);
        ovf_clr = 0;
        udf_clr = 0;
        check_outs(tag);
    endtask

    task automatic idle();
        last_counter = 8'h05;
        counter_signal = 8'h05;
    endtask

    task automatic clear_all();
        idle();
        TCR = 8'h10;
        ovf_clr = 1;
        udf_clr = 1;
        step("clr");
    endtask

    task automatic up_evt();
        TCR = 8'h10; last_counter = 8'hFF; counter_signal = 8'h00;
    endtask

    task automatic dn_evt();
        TCR = 8'h18; last_counter = 8'h00; counter_signal = 8'hFF;
    endtask

    initial begin
        preset_n = 1; TCR = 8'h00; ovf_clr = 0; udf_clr = 0;
        ovf_ie = 1; udf_ie = 1;
        idle();
        m_reset();
        repeat (2) @(negedge pclk);
        chk("rst.tsr", {4'h0, TSR}, 8'h00);
        chk("rst.oirq", {7'h0, tmr_ovf_irq}, 8'h00);
        preset_n = 0;
        idle(); TCR = 8'h10;
        step("idle");

        // Up wrap
        up_evt(); ovf_ie = 1;
        step("up");
        chk("up.tsr", {4'h0, TSR}, 8'h01);
        chk("up.irq", {7'h0, tmr_ovf_irq}, 8'h01);
        clear_all();

        // Down wrap with interrupt disabled
        dn_evt(); udf_ie = 0;
        step("dn");
        chk("dn.tsr", {4'h0, TSR}, 8'h02);
        chk("dn.irq", {7'h0, tmr_udf_irq}, 8'h00);
        udf_ie = 1;
        #1 chk("ie.irq", {7'h0, tmr_udf_irq}, 8'h01);
        clear_all();

        // Load masking: load cycle then a wrap-looking cycle
        TCR = 8'h90; last_counter = 8'hFF; counter_signal = 8'h00;
        step("ld1");
        up_evt();
        step("ld2");
        chk("load.tsr", {4'h0, TSR}, 8'h00);

        // Hold at 00 / FF is never an event
        TCR = 8'h10; last_counter = 8'h00; counter_signal = 8'h00;
        step("hold0");
        TCR = 8'h18; last_counter = 8'hFF; counter_signal = 8'hFF;
        step("holdF");
        chk("hold.tsr", {4'h0, TSR}, 8'h00);

        // Clear with nothing pending
        idle(); ovf_clr = 1; udf_clr = 1;
        step("clr0");

        // Overrun then clear
        up_evt(); step("or1");
        up_evt(); step("or2");
        chk("ovr.tsr", {4'h0, TSR}, 8'h05);
        idle(); ovf_clr = 1;
        step("or3");
        chk("ovr.clr", {4'h0, TSR}, 8'h00);

        // Collision: event with clear while flag set
        up_evt(); step("col1");
        up_evt(); ovf_clr = 1;
        step("col2");
        chk("col.tsr", {4'h0, TSR}, 8'h01);
        clear_all();

        // Reset mid-operation with all bits set
        up_evt(); step("f1");
        up_evt(); step("f2");
        dn_evt(); step("f3");
        dn_evt(); step("f4");
        chk("full.tsr", {4'h0, TSR}, 8'h0F);
        up_evt();
        #1 preset_n = 1;
        m_reset();
        #1;
        chk("amid.tsr", {4'h0, TSR}, 8'h00);
        chk("amid.oirq", {7'h0, tmr_ovf_irq}, 8'h00);
        chk("amid.uirq", {7'h0, tmr_udf_irq}, 8'h00);
        @(negedge pclk);
        preset_n = 0;
        idle();
        step("rel");
        chk("rel.tsr", {4'h0, TSR}, 8'h00);
        up_evt(); step("first");
        chk("first.tsr", {4'h0, TSR}, 8'h01);

        // Randomized traffic biased toward wraps
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: begin last_counter = 8'hFF; counter_signal = 8'h00; end
                1: begin last_counter = 8'h00; counter_signal = 8'hFF; end
                2: begin
                    last_counter = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'hFF;
                    counter_signal = last_counter;
                end
                default: begin
                    last_counter = 8'($urandom);
                    counter_signal = 8'($urandom);
                end
            endcase
            case ($urandom_range(0, 4))
                0: TCR = 8'h10;
                1: TCR = 8'h18;
                2: TCR = 8'h90;
                3: TCR = 8'h98;
                default: TCR = 8'($urandom);
            endcase
            ovf_clr = ($urandom_range(0, 3) == 0);
            udf_clr = ($urandom_range(0, 3) == 0);
            step("rnd");
            if ($urandom_range(0, 7) == 0) begin
                ovf_ie = ~ovf_ie;
                udf_ie = 1'($urandom);
                #1 check_outs("rnd_ie");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer_status.md
TIMER_STATUS -- requirements
Module: timer_status

Interface
REQ-001 SHALL have the following ports, one per line: name, direction, width, meaning.
- pclk  in  1  system clock; all state on its rising edge.
- preset_n  in  1  asynchronous, active-high reset; the name is retained, the polarity is high.
- counter_signal  in  8  current counter value.
- last_counter  in  8  counter value delayed by one pclk.
- TCR  in  8  timer control register: bit7 load, bit4 enable, bit3 direction (1 = down).
- ovf_clr  in  1  single-pclk strobe; clears overflow flag and overflow overrun bit.
- udf_clr  in  1  single-pclk strobe; clears underflow flag and underflow overrun bit.
- ovf_ie  in  1  overflow interrupt enable.
- udf_ie  in  1  underflow interrupt enable.
- TSR  out  4  status: bit0 ovf, bit1 udf, bit2 ovf_overrun, bit3 udf_overrun.
- tmr_ovf_irq  out  1  overflow interrupt, level.
- tmr_udf_irq  out  1  underflow interrupt, level.
REQ-002 SHALL have no parameters; width is fixed at 8 bits.

Function
REQ-003 SHALL register TCR[7] each cycle into load_d, reset value 0.
REQ-004 SHALL detect an overflow event in the cycle where all of these hold:
- last_counter == 8'hFF
- counter_signal == 8'h00
- TCR[3] == 0
- TCR[7] == 0
- load_d == 0
REQ-005 SHALL detect an underflow event in the cycle where all of these hold:
- last_counter == 8'h00
- counter_signal == 8'hFF
- TCR[3] == 1
- TCR[7] == 0
- load_d == 0
REQ-006 SHALL NOT require TCR[4] == 1 for detection; a wrap only occurs while counting is enabled.
REQ-007 SHALL produce no event when counter_signal == last_counter (counter holding), including a hold at 00 or FF.
REQ-008 SHALL set TSR[0] one pclk after an overflow event is detected, i.e. on the rising edge ending the detect cycle.
REQ-009 SHALL set TSR[1] one pclk after an underflow event is detected, with the same timing as REQ-008.
REQ-010 SHALL keep TSR[0] and TSR[1] sticky until cleared by the matching strobe.
REQ-011 SHALL set TSR[2] when an overflow event occurs while TSR[0] is already 1 and ovf_clr is 0 in that cycle.
REQ-012 SHALL set TSR[3] under the same rule as REQ-011, using underflow, TSR[1] and udf_clr.
REQ-013 SHALL, on ovf_clr, clear TSR[0] and TSR[2] at the next edge; udf_clr SHALL do the same for TSR[1] and TSR[3].
REQ-014 SHALL give set priority over clear when an event and its clear strobe coincide:
- the flag ends at 1;
- the overrun bit ends at 0.
REQ-015 SHALL drive tmr_ovf_irq = TSR[0] & ovf_ie and tmr_udf_irq = TSR[1] & udf_ie combinationally from the registered flags.
REQ-016 SHALL let a clear strobe with no flag pending leave all state unchanged.
REQ-017 SHALL let an interrupt-enable change act on the IRQ outputs in the same cycle, without affecting the flags.

Reset
REQ-018 SHALL, while preset_n is high, asynchronously force load_d = 0, TSR = 4'h0, tmr_ovf_irq = 0 and tmr_udf_irq = 0.
REQ-019 SHALL discard any detection pending in the cycle reset asserts mid-operation; no flag sets at reset release.
REQ-020 SHALL let the first event after reset release set only the flag, never the overrun bit.

Structure
REQ-021 SHALL take the following constants from the shared package timer_pkg, which the counter block also uses:
- TCR_LOAD = 7, TCR_EN = 4, TCR_DIR = 3
- TSR_OVF = 0, TSR_UDF = 1, TSR_OVF_OR = 2, TSR_UDF_OR = 3
REQ-022 SHALL place the wrap comparison (REQ-004..REQ-007) in sub-module wrap_detect, instantiated once, with outputs ovf_evt and udf_evt.
REQ-023 SHALL keep the flag and overrun registers and the IRQ logic in timer_status itself.

Verification
REQ-024 Up wrap:
- stimulus: TCR = 8'h10, last_counter = FF, counter_signal = 00 for one cycle;
- response: TSR = 4'h1 next cycle; tmr_ovf_irq = 1 with ovf_ie = 1.
REQ-025 Down wrap:
- stimulus: TCR = 8'h18, last_counter = 00, counter_signal = FF;
- response: TSR = 4'h2; tmr_udf_irq stays 0 with udf_ie = 0.
REQ-026 Load masking:
- stimulus: TCR = 8'h90 for one cycle (TDR = 00 while counter = FF), then TCR = 8'h10 with last_counter = FF, counter_signal = 00;
- response: TSR stays 4'h0.
REQ-027 Overrun:
- stimulus: two overflow events with no ovf_clr between them;
- response: TSR = 4'h5; after ovf_clr, TSR = 4'h0.
REQ-028 Collision:
- stimulus: overflow event and ovf_clr in the same cycle with TSR[0] = 1;
- response: TSR[0] = 1, TSR[2] = 0.
REQ-029 Reset mid-operation:
- stimulus: assert preset_n during an event cycle with TSR = 4'hF;
- response: TSR = 0 and both IRQs = 0 immediately; no flag after release.
